// File: rtl/scaler_cfggen_multi_pkg.sv
// rtl/scaler_cfggen_multi_pkg.sv - shared defaults, engine states and video size constants
package scaler_cfggen_multi_pkg;

    localparam int DEF_NUM_AXES    = 2;
    localparam int DEF_SRC_W       = 10;
    localparam int DEF_DST_W       = 12;
    localparam int DEF_FRAC_W      = 18;
    localparam int DEF_AUTO_COMMIT = 0;

    // Typical N64 active sizes
    localparam int ACTIVE_LINES_NTSC     = 240;
    localparam int ACTIVE_LINES_PAL      = 288;
    localparam int ACTIVE_PIXEL_PER_LINE = 640;

    typedef enum logic [2:0] {
        ENG_IDLE  = 3'd0,
        ENG_DIV   = 3'd1,
        ENG_MUL1  = 3'd2,
        ENG_MUL2  = 3'd3,
        ENG_CLAMP = 3'd4,
        ENG_STORE = 3'd5
    } eng_state_e;

    // Index width for an axis number; never below one bit
    function automatic int ax_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scaler_cfggen_multi_divide.sv
// rtl/scaler_cfggen_multi_divide.sv - serial reciprocal divider, floor(2^DIVIDEND_WIDTH / divisor), saturating
module serial_divide
    import scaler_cfggen_multi_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_FRAC_W,
    parameter int DIVISOR_WIDTH  = DEF_DST_W
) (
    input  logic                      clk_i,
    input  logic                      nrst_i,
    input  logic                      start_i,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
    output logic [DIVIDEND_WIDTH-1:0] quotient_o,
    output logic                      done_o
);

    // The dividend is a one followed by DIVIDEND_WIDTH zeros, so one extra step
    localparam int STEPS = DIVIDEND_WIDTH + 1;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [DIVISOR_WIDTH-1:0]  divisor_q;
    logic [DIVISOR_WIDTH-1:0]  rem_q;
    logic [DIVIDEND_WIDTH:0]   quo_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      done_q;

    logic                      bit_in;
    logic [DIVISOR_WIDTH:0]    trial;
    logic                      ge;
    logic [DIVISOR_WIDTH:0]    rem_next;

    assign bit_in   = (cnt_q == CNT_W'(STEPS));
    assign trial    = {rem_q, bit_in};
    assign ge       = (trial >= {1'b0, divisor_q});
    assign rem_next = ge ? (trial - {1'b0, divisor_q}) : trial;

    // Restoring division, one quotient bit per cycle, MSB first
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else if (start_i) begin
            divisor_q <= divisor_i;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= CNT_W'(STEPS);
            done_q    <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q     <= DIVISOR_WIDTH'(rem_next);
            quo_q     <= {quo_q[DIVIDEND_WIDTH-1:0], ge};
            cnt_q     <= cnt_q - 1'b1;
            done_q    <= (cnt_q == CNT_W'(1));
        end else begin
            done_q    <= 1'b0;
        end
    end

    // Divisor 1 (and 0) would need one more bit; clamp to all ones
    assign quotient_o = quo_q[DIVIDEND_WIDTH] ? {DIVIDEND_WIDTH{1'b1}} : quo_q[DIVIDEND_WIDTH-1:0];
    assign done_o     = done_q;

endmodule

// File: rtl/scaler_cfggen_multi.sv
// rtl/scaler_cfggen_multi.sv - multi-axis scaler config generator sharing one serial divider
module scaler_cfggen_multi
    import scaler_cfggen_multi_pkg::*;
#(
    parameter int NUM_AXES    = DEF_NUM_AXES,
    parameter int SRC_W       = DEF_SRC_W,
    parameter int DST_W       = DEF_DST_W,
    parameter int FRAC_W      = DEF_FRAC_W,
    parameter int AUTO_COMMIT = DEF_AUTO_COMMIT
) (
    input  logic                         SYS_CLK,
    input  logic                         nRST,
    input  logic [NUM_AXES*SRC_W-1:0]    src_size_i,
    input  logic [NUM_AXES*DST_W-1:0]    dst_active_i,
    input  logic [NUM_AXES*DST_W-1:0]    dst_scaled_i,
    input  logic                         frame_sync_i,
    output logic [NUM_AXES*FRAC_W-1:0]   interp_factor_o,
    output logic [NUM_AXES*SRC_W-1:0]    in_needed_o,
    output logic [NUM_AXES*SRC_W-1:0]    first_pos_o,
    output logic [NUM_AXES*DST_W-1:0]    dst_scaled_o,
    output logic                         cfg_valid_o,
    output logic                         cfg_update_o,
    output logic                         busy_o
);

    localparam int AX_W   = ax_width(NUM_AXES);
    localparam int INV_W  = FRAC_W + SRC_W;
    localparam int FULL_W = INV_W + DST_W;
    localparam int RAW_W  = FULL_W + 1 - FRAC_W;
    localparam logic [FULL_W:0]   ROUND_HALF = (FULL_W+1)'(1) << (FRAC_W - 1);
    localparam logic [FRAC_W-1:0] FACTOR_MAX = '1;

    logic [SRC_W-1:0]  src_in      [NUM_AXES];
    logic [DST_W-1:0]  act_in      [NUM_AXES];
    logic [DST_W-1:0]  scl_in      [NUM_AXES];
    logic [SRC_W-1:0]  lat_src_q   [NUM_AXES];
    logic [DST_W-1:0]  lat_act_q   [NUM_AXES];
    logic [DST_W-1:0]  lat_scl_q   [NUM_AXES];
    logic [FRAC_W-1:0] sh_fac_q    [NUM_AXES];
    logic [SRC_W-1:0]  sh_need_q   [NUM_AXES];
    logic [SRC_W-1:0]  sh_pos_q    [NUM_AXES];
    logic [DST_W-1:0]  sh_scl_q    [NUM_AXES];
    logic [FRAC_W-1:0] out_fac_q   [NUM_AXES];
    logic [SRC_W-1:0]  out_need_q  [NUM_AXES];
    logic [SRC_W-1:0]  out_pos_q   [NUM_AXES];
    logic [DST_W-1:0]  out_scl_q   [NUM_AXES];

    logic [NUM_AXES-1:0] dirty_q, dirty_d;
    logic [AX_W-1:0]     last_q, grant_idx, cur_q;
    logic                grant, found, commit;
    int                  idx;
    eng_state_e          state_q, state_d;

    logic                div_start, div_done, div0_q;
    logic [FRAC_W-1:0]   div_quot, fac_w, factor_q;
    logic [INV_W-1:0]    inv_q;
    logic [FULL_W:0]     sum_w;
    logic [RAW_W-1:0]    raw_w, raw_q;
    logic [SRC_W-1:0]    need_q, pos_q;
    logic                shadow_new_q, cfg_valid_q, cfg_update_q, busy_q;

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        assign src_in[a] = src_size_i[a*SRC_W +: SRC_W];
        assign act_in[a] = dst_active_i[a*DST_W +: DST_W];
        assign scl_in[a] = dst_scaled_i[a*DST_W +: DST_W];
        assign interp_factor_o[a*FRAC_W +: FRAC_W] = out_fac_q[a];
        assign in_needed_o[a*SRC_W +: SRC_W]       = out_need_q[a];
        assign first_pos_o[a*SRC_W +: SRC_W]       = out_pos_q[a];
        assign dst_scaled_o[a*DST_W +: DST_W]      = out_scl_q[a];
    end

    assign grant  = (state_q == ENG_IDLE) && (|dirty_q);
    assign commit = shadow_new_q && !(|dirty_q) && (state_q == ENG_IDLE) &&
                    (frame_sync_i || (AUTO_COMMIT != 0));

    // Round-robin pick: first dirty axis after the one served last
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_AXES; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_AXES) idx = idx - NUM_AXES;
            if (!found && dirty_q[AX_W'(idx)]) begin
                found     = 1'b1;
                grant_idx = AX_W'(idx);
            end
        end
    end

    // An axis becomes dirty whenever its live inputs differ from the snapshot
    always_comb begin
        dirty_d = dirty_q;
        for (int a = 0; a < NUM_AXES; a++) begin
            if ((src_in[a] != lat_src_q[a]) || (act_in[a] != lat_act_q[a]) ||
                (scl_in[a] != lat_scl_q[a]))
                dirty_d[a] = 1'b1;
            if (grant && (grant_idx == AX_W'(a)))
                dirty_d[a] = 1'b0;
        end
    end

    // Snapshot the granted axis inputs; these are the job operands
    always_ff @(posedge SYS_CLK or negedge nRST) begin
        if (!nRST) begin
            for (int a = 0; a < NUM_AXES; a++) begin
                lat_src_q[a] <= '0;
                lat_act_q[a] <= '0;
                lat_scl_q[a] <= '0;
            end
            dirty_q <= '1;
            last_q  <= AX_W'(NUM_AXES - 1);
        end else begin
            dirty_q <= dirty_d;
            if (grant) begin
                lat_src_q[grant_idx] <= src_in[grant_idx];
                lat_act_q[grant_idx] <= act_in[grant_idx];
                lat_scl_q[grant_idx] <= scl_in[grant_idx];
                last_q               <= grant_idx;
            end
        end
    end

    // Engine state register
    always_ff @(posedge SYS_CLK or negedge nRST) begin
        if (!nRST) state_q <= ENG_IDLE;
        else       state_q <= state_d;
    end

    // Engine sequencing; a zero divisor bypasses the divider entirely
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            ENG_IDLE: begin
                if (grant) begin
                    if (scl_in[grant_idx] == '0) begin
                        state_d = ENG_MUL1;
                    end else begin
                        state_d   = ENG_DIV;
                        div_start = 1'b1;
                    end
                end
            end
            ENG_DIV:   if (div_done) state_d = ENG_MUL1;
            ENG_MUL1:  state_d = ENG_MUL2;
            ENG_MUL2:  state_d = ENG_CLAMP;
            ENG_CLAMP: state_d = ENG_STORE;
            ENG_STORE: state_d = ENG_IDLE;
            default:   state_d = ENG_IDLE;
        endcase
    end

    serial_divide #(
        .DIVIDEND_WIDTH (FRAC_W),
        .DIVISOR_WIDTH  (DST_W)
    ) u_div (
        .clk_i      (SYS_CLK),
        .nrst_i     (nRST),
        .start_i    (div_start),
        .divisor_i  (scl_in[grant_idx]),
        .quotient_o (div_quot),
        .done_o     (div_done)
    );

    assign fac_w = div0_q ? FACTOR_MAX : div_quot;
    assign sum_w = (FULL_W+1)'(inv_q) * (FULL_W+1)'(lat_act_q[cur_q]) + ROUND_HALF;
    assign raw_w = RAW_W'(sum_w >> FRAC_W);

    // Datapath: one arithmetic step per engine state
    always_ff @(posedge SYS_CLK or negedge nRST) begin
        if (!nRST) begin
            cur_q    <= '0;
            div0_q   <= 1'b0;
            factor_q <= '0;
            inv_q    <= '0;
            raw_q    <= '0;
            need_q   <= '0;
            pos_q    <= '0;
        end else begin
            case (state_q)
                ENG_IDLE: begin
                    if (grant) begin
                        cur_q  <= grant_idx;
                        div0_q <= (scl_in[grant_idx] == '0);
                    end
                end
                ENG_MUL1: begin
                    factor_q <= fac_w;
                    inv_q    <= INV_W'(fac_w) * INV_W'(lat_src_q[cur_q]);
                end
                ENG_MUL2: raw_q <= raw_w;
                ENG_CLAMP: begin
                    if (div0_q || (raw_q >= RAW_W'(lat_src_q[cur_q]))) begin
                        need_q <= lat_src_q[cur_q];
                        pos_q  <= '0;
                    end else begin
                        need_q <= raw_q[SRC_W-1:0];
                        pos_q  <= (lat_src_q[cur_q] - raw_q[SRC_W-1:0]) >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow write on STORE, atomic copy of every axis to the outputs on commit
    always_ff @(posedge SYS_CLK or negedge nRST) begin
        if (!nRST) begin
            for (int a = 0; a < NUM_AXES; a++) begin
                sh_fac_q[a]   <= '0;
                sh_need_q[a]  <= '0;
                sh_pos_q[a]   <= '0;
                sh_scl_q[a]   <= '0;
                out_fac_q[a]  <= '0;
                out_need_q[a] <= '0;
                out_pos_q[a]  <= '0;
                out_scl_q[a]  <= '0;
            end
            shadow_new_q <= 1'b0;
            cfg_valid_q  <= 1'b0;
            cfg_update_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cfg_update_q <= commit;
            busy_q       <= (|dirty_d) || (state_d != ENG_IDLE);
            if (state_q == ENG_STORE) begin
                sh_fac_q[cur_q]  <= factor_q;
                sh_need_q[cur_q] <= need_q;
                sh_pos_q[cur_q]  <= pos_q;
                sh_scl_q[cur_q]  <= lat_scl_q[cur_q];
                shadow_new_q     <= 1'b1;
            end else if (commit) begin
                for (int a = 0; a < NUM_AXES; a++) begin
                    out_fac_q[a]  <= sh_fac_q[a];
                    out_need_q[a] <= sh_need_q[a];
                    out_pos_q[a]  <= sh_pos_q[a];
                    out_scl_q[a]  <= sh_scl_q[a];
                end
                shadow_new_q <= 1'b0;
                cfg_valid_q  <= 1'b1;
            end
        end
    end

    assign cfg_valid_o  = cfg_valid_q;
    assign cfg_update_o = cfg_update_q;
    assign busy_o       = busy_q;

endmodule
